// File: rtl/iterative_divider.sv
// iterative_divider: restoring shift-subtract divider, one quotient bit per clock.
// Serves MIPS DIV/DIVU; quotient goes to LO, remainder to HI.
module iterative_divider #(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             signed_i,
   input  logic [WIDTH-1:0] dividend_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] quotient_o,
   output logic [WIDTH-1:0] remainder_o,
   output logic             div_zero_o
);
   localparam int CW = $clog2(WIDTH + 1);
   typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
   state_t           state_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] rem_q, quo_q, dvs_q, rem_d, quo_d, dvd_abs, dvs_abs;
   logic [WIDTH-1:0] quotient_q, remainder_q;
   logic [WIDTH:0]   shift;
   logic             qneg_q, rneg_q, busy_q, done_q, div_zero_q;
   logic             dvd_neg, dvs_neg, ge, accept;
   always_comb begin
      dvd_neg = signed_i & dividend_i[WIDTH-1];
      dvs_neg = signed_i & divisor_i[WIDTH-1];
      dvd_abs = dvd_neg ? -dividend_i : dividend_i;
      dvs_abs = dvs_neg ? -divisor_i : divisor_i;
      shift   = {rem_q, quo_q[WIDTH-1]};
      ge      = shift >= {1'b0, dvs_q};
      rem_d   = ge ? WIDTH'(shift - {1'b0, dvs_q}) : shift[WIDTH-1:0];
      quo_d   = {quo_q[WIDTH-2:0], ge};
      accept  = start_i && (state_q == IDLE || state_q == DONE);
   end
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         rem_q       <= '0;
         quo_q       <= '0;
         dvs_q       <= '0;
         qneg_q      <= 1'b0;
         rneg_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
         div_zero_q  <= 1'b0;
      end else if (accept) begin
         qneg_q <= dvd_neg ^ dvs_neg;
         rneg_q <= dvd_neg;
         quo_q  <= dvd_abs;
         rem_q  <= '0;
         dvs_q  <= dvs_abs;
         cnt_q  <= '0;
         if (divisor_i == '0) begin
            // Zero divisor bypasses the iteration and reports immediately.
            state_q     <= DONE;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            quotient_q  <= '1;
            remainder_q <= dividend_i;
            div_zero_q  <= 1'b1;
         end else begin
            state_q    <= RUN;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
         end
      end else begin
         case (state_q)
            RUN: begin
               rem_q <= rem_d;
               quo_q <= quo_d;
               cnt_q <= cnt_q + CW'(1);
               if (cnt_q == CW'(WIDTH - 1)) state_q <= FIX;
            end
            FIX: begin
               quotient_q  <= qneg_q ? -quo_q : quo_q;
               remainder_q <= rneg_q ? -rem_q : rem_q;
               state_q     <= DONE;
               busy_q      <= 1'b0;
               done_q      <= 1'b1;
            end
            default: begin
               state_q <= IDLE;
               done_q  <= 1'b0;
            end
         endcase
      end
   end
   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign quotient_o  = quotient_q;
   assign remainder_o = remainder_q;
   assign div_zero_o  = div_zero_q;
endmodule

// File: tb/tb_iterative_divider.sv
// tb_iterative_divider: directed vector table plus handshake, back-to-back and reset sequences.
module tb_iterative_divider;
   logic        clk_i = 1'b0, rst_i = 1'b0, start_i = 1'b0, signed_i = 1'b0;
   logic [31:0] dividend_i = '0, divisor_i = '0;
   logic        busy_o, done_o, div_zero_o;
   logic [31:0] quotient_o, remainder_o;
   int          n_cmp = 0, n_bad = 0;

   iterative_divider #(.WIDTH(32)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .signed_i(signed_i),
      .dividend_i(dividend_i), .divisor_i(divisor_i), .busy_o(busy_o), .done_o(done_o),
      .quotient_o(quotient_o), .remainder_o(remainder_o), .div_zero_o(div_zero_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic        sgn;
      logic [31:0] dvd, dvs, q, r;
      logic        z;
   } vec_t;
   vec_t vecs[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Drives a request for one edge; returns 1ns after the accepting edge.
   task automatic launch(input logic sgn, input logic [31:0] dvd, input logic [31:0] dvs);
      @(negedge clk_i);
      signed_i = sgn; dividend_i = dvd; divisor_i = dvs; start_i = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
   endtask

   task automatic wait_done(input string name, input int lat, input logic [31:0] q,
                            input logic [31:0] r, input logic z);
      int n = 0;
      while (done_o !== 1'b1 && n < 80) begin
         @(posedge clk_i); #1;
         n++;
      end
      chk({name, " latency"}, n, lat);
      chk({name, " busy@done"}, {31'b0, busy_o}, 32'd0);
      chk({name, " q"}, quotient_o, q);
      chk({name, " r"}, remainder_o, r);
      chk({name, " div_zero"}, {31'b0, div_zero_o}, {31'b0, z});
   endtask

   initial begin
      vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
      vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0};
      vecs[2]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          1'b0};
      vecs[3]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0};
      vecs[4]  = '{1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          1'b0};
      vecs[5]  = '{1'b0, 32'd5,          32'd0,          32'hFFFFFFFF,   32'd5,          1'b1};
      vecs[6]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
      vecs[7]  = '{1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE,   32'd3,          32'hFFFFFFFF,   1'b0};
      vecs[8]  = '{1'b0, 32'hFFFFFFF9,   32'd2,          32'h7FFFFFFC,   32'd1,          1'b0};
      vecs[9]  = '{1'b1, 32'd0,          32'd0,          32'hFFFFFFFF,   32'd0,          1'b1};
      vecs[10] = '{1'b0, 32'd3,          32'd5,          32'd0,          32'd3,          1'b0};
      vecs[11] = '{1'b1, 32'hFFFFFFF9,   32'd0,          32'hFFFFFFFF,   32'hFFFFFFF9,   1'b1};

      #12;
      chk("reset busy", {31'b0, busy_o}, 32'd0);
      chk("reset done", {31'b0, done_o}, 32'd0);
      chk("reset q", quotient_o, 32'd0);
      chk("reset r", remainder_o, 32'd0);
      chk("reset div_zero", {31'b0, div_zero_o}, 32'd0);
      @(negedge clk_i); rst_i = 1'b1;

      foreach (vecs[i]) begin
         launch(vecs[i].sgn, vecs[i].dvd, vecs[i].dvs);
         chk($sformatf("vec%0d busy@accept", i), {31'b0, busy_o}, {31'b0, ~vecs[i].z});
         wait_done($sformatf("vec%0d", i), vecs[i].z ? 0 : 33, vecs[i].q, vecs[i].r, vecs[i].z);
         @(posedge clk_i); #1;
         chk($sformatf("vec%0d done pulse", i), {31'b0, done_o}, 32'd0);
      end

      // A start pulse mid-RUN must be ignored.
      launch(1'b0, 32'd100, 32'd7);
      repeat (4) @(posedge clk_i);
      @(negedge clk_i);
      dividend_i = 32'd50; divisor_i = 32'd5; start_i = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      wait_done("ignored start", 28, 32'd14, 32'd2, 1'b0);

      // Start issued in the DONE cycle is accepted with no bubble.
      start_i = 1'b1; signed_i = 1'b0; dividend_i = 32'd200; divisor_i = 32'd3;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      chk("b2b busy", {31'b0, busy_o}, 32'd1);
      wait_done("b2b", 33, 32'd66, 32'd2, 1'b0);

      // Asynchronous reset mid-RUN discards the operation.
      launch(1'b0, 32'd100, 32'd7);
      repeat (9) @(posedge clk_i);
      #1 rst_i = 1'b0;
      #1;
      chk("rst busy", {31'b0, busy_o}, 32'd0);
      chk("rst q", quotient_o, 32'd0);
      chk("rst r", remainder_o, 32'd0);
      begin
         int seen = 0;
         repeat (3) begin
            @(posedge clk_i); #1;
            if (done_o === 1'b1) seen++;
         end
         @(negedge clk_i); rst_i = 1'b1;
         repeat (40) begin
            @(posedge clk_i); #1;
            if (done_o === 1'b1) seen++;
         end
         chk("rst no done", seen, 0);
      end
      launch(1'b0, 32'd100, 32'd7);
      wait_done("post-rst", 33, 32'd14, 32'd2, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
      $finish;
   end
endmodule
